// File: rtl/comparator_seq_if.sv
// Operand/result bundle for the chunk-serial magnitude comparator.
// The master drives a request and the slave returns busy/done and the held result flags.
interface comparator_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             AgB;
  logic             AeB;
  logic             AlB;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, AgB, AeB, AlB
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, AgB, AeB, AlB
  );
endinterface

// File: rtl/comparator_seq.sv
// Sequential magnitude comparator: walks STEP-bit chunks from MSB to LSB and
// exits early on the first differing chunk. Signed order uses an MSB flip at capture.
module comparator_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  comparator_seq_if.slave  bus
);
  localparam int N    = WIDTH / STEP;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            nextState_s;
  logic [WIDTH-1:0]  aCap_r;
  logic [WIDTH-1:0]  bCap_r;
  logic [IDXW-1:0]   idx_r;
  logic [STEP-1:0]   chunkA_s;
  logic [STEP-1:0]   chunkB_s;
  logic              busy_r;
  logic              done_r;
  logic              greater_r;
  logic              equal_r;
  logic              less_r;
  logic              busyNext_s;
  logic              doneNext_s;
  logic              greaterNext_s;
  logic              equalNext_s;
  logic              lessNext_s;

  assign chunkA_s = aCap_r[int'(idx_r) * STEP +: STEP];
  assign chunkB_s = bCap_r[int'(idx_r) * STEP +: STEP];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state logic: early exit on the first unequal chunk.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          nextState_s = RUN;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        if (chunkA_s != chunkB_s) begin
          nextState_s = DONE;
        end else if (idx_r == {IDXW{1'b0}}) begin
          nextState_s = DONE;
        end else begin
          nextState_s = RUN;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Output logic: next values for the registered status and result flags.
  always_comb begin
    busyNext_s    = (nextState_s != IDLE);
    doneNext_s    = (nextState_s == DONE);
    greaterNext_s = greater_r;
    equalNext_s   = equal_r;
    lessNext_s    = less_r;
    if ((state_r == RUN) && (nextState_s == DONE)) begin
      greaterNext_s = (chunkA_s > chunkB_s);
      equalNext_s   = (chunkA_s == chunkB_s);
      lessNext_s    = (chunkA_s < chunkB_s);
    end else begin
      greaterNext_s = greater_r;
      equalNext_s   = equal_r;
      lessNext_s    = less_r;
    end
  end

  // Operand capture, chunk index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      aCap_r    <= {WIDTH{1'b0}};
      bCap_r    <= {WIDTH{1'b0}};
      idx_r     <= {IDXW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      greater_r <= 1'b0;
      equal_r   <= 1'b0;
      less_r    <= 1'b0;
    end else begin
      if ((state_r == IDLE) && bus.start) begin
        // Flipping both MSBs maps two's complement order onto unsigned order.
        aCap_r <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
        bCap_r <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
        idx_r  <= IDXW'(N - 1);
      end else if (state_r == RUN) begin
        idx_r  <= idx_r - 1'b1;
      end else begin
        idx_r  <= idx_r;
      end
      busy_r    <= busyNext_s;
      done_r    <= doneNext_s;
      greater_r <= greaterNext_s;
      equal_r   <= equalNext_s;
      less_r    <= lessNext_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.AgB  = greater_r;
  assign bus.AeB  = equal_r;
  assign bus.AlB  = less_r;
endmodule

// File: doc/comparator_seq.md
COMPARATOR_SEQ -- requirements
Module: comparator_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal values: >=2, a multiple of STEP).
REQ-002 The block SHALL have parameter STEP, default 2, giving the bits compared per cycle (legal values: >=1, divides WIDTH).
REQ-003 clk  input  1  Sole clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  Reset, synchronous and active-high.
REQ-005 start  input  1  Request a comparison; accepted only while busy=0.
REQ-006 signed_mode  input  1  When 1, operands are two's complement; when 0, unsigned; sampled with start.
REQ-007 a  input  WIDTH  Operand A; sampled on the accepting edge.
REQ-008 b  input  WIDTH  Operand B; sampled on the accepting edge.
REQ-009 busy  output  1  High whenever the state is not IDLE.
REQ-010 done  output  1  Single-cycle pulse that marks a new result.
REQ-011 AgB  output  1  A greater than B; registered, held until the next result or reset.
REQ-012 AeB  output  1  A equal to B; registered, held.
REQ-013 AlB  output  1  A less than B; registered, held.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL capture a, b and signed_mode, load chunk index N-1 (where N=WIDTH/STEP), and move to RUN.
REQ-016 In signed mode, the captured MSB of both operands SHALL be inverted, so that unsigned chunk comparison yields the signed order.
REQ-017 Each RUN cycle SHALL compare exactly one STEP-bit chunk, starting at the most significant chunk and moving toward the least significant.
REQ-018 If a chunk of A is greater than the corresponding chunk of B, the block SHALL record GT and go to DONE (early exit).
REQ-019 If a chunk of A is less than the corresponding chunk of B, the block SHALL record LT and go to DONE (early exit).
REQ-020 If the chunks are equal and the index is 0, the block SHALL record EQ and go to DONE; otherwise it SHALL decrement the index and stay in RUN.
REQ-021 The result SHALL be written to AgB/AeB/AlB on the edge that enters DONE.
REQ-022 done SHALL be 1 only while in DONE, and DONE SHALL last exactly one cycle before returning to IDLE.
REQ-023 Latency: with start accepted at edge t and the first differing chunk at position k (1 = MSB chunk, N if all chunks are equal), RUN SHALL occupy k cycles and done SHALL be high in cycle t+k+1.
REQ-024 After the first result, exactly one of AgB, AeB, AlB SHALL be high.
REQ-025 start while busy=1 (including the DONE cycle) SHALL be ignored, with no effect on the captured operands or the result.
REQ-026 Changes on a, b or signed_mode after acceptance SHALL NOT affect the comparison in progress.
REQ-027 Back-to-back operation: a start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-028 When rst=1 at an edge, the block SHALL set the state to IDLE and clear busy, done, AgB, AeB and AlB to 0, taking priority over start.
REQ-029 rst asserted mid-RUN or in DONE SHALL abandon the operation; no done pulse SHALL follow.
REQ-030 Before the first result, all three compare outputs SHALL read 0.

Verification (WIDTH=8, STEP=2)
REQ-031 Unsigned, a=0xC0, b=0x40 -> RUN lasts 1 cycle, done at t+2, AgB=1.
REQ-032 a=b=0x5A -> RUN lasts 4 cycles, done at t+5, AeB=1.
REQ-033 a=0x80, b=0x01: signed -> AlB=1 at t+2; unsigned -> AgB=1 at t+2.
REQ-034 a=0x03, b=0x02 -> AgB=1, done at t+5; a start pulse and operand changes during RUN -> ignored, result unchanged.
REQ-035 rst pulsed in the second RUN cycle of a 4-chunk compare -> next cycle busy=0, all outputs 0, no done pulse.
REQ-036 Back-to-back: a start in the IDLE cycle right after done -> accepted, and the second result is correct.
